// File: rtl/fifo_pkg.sv
// Shared constants and Gray/binary pointer conversions for the async FIFO
// read- and write-side controllers.
package fifo_pkg;

  localparam int ADDR_WIDTH = 4;

  // Conversions work on a 32-bit container; narrower pointers are zero-extended
  // by the caller and the result sliced back, which leaves the low bits exact.
  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] gray);
    logic [31:0] bin;
    bin[31] = gray[31];
    for (int i = 30; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/fifo_rd_ctrl.sv
// Read-domain pointer and flag controller of the asynchronous FIFO: read
// address, Gray read pointer for the write domain, empty/level/underflow.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = fifo_pkg::ADDR_WIDTH,
  parameter int AEMPTY_TH  = 2
) (
  input  logic                  Dst_clk,
  input  logic                  rst,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH:0]   sync_wptr,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [ADDR_WIDTH:0]   rd_ptr,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   rd_level,
  output logic                  rd_underflow
);

  localparam int PTR_W = ADDR_WIDTH + 1;
  localparam logic [PTR_W-1:0] AE_TH = PTR_W'(AEMPTY_TH);

  logic [PTR_W-1:0] rd_bin_q, rd_bin_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_gray_d;
  logic [PTR_W-1:0] level_q, level_d;
  logic [PTR_W-1:0] w_bin;
  logic [31:0]      gray_wide, wbin_wide;
  logic             empty_q, aempty_q, underflow_q;
  logic             rd_inc;

  always_comb begin
    rd_inc    = rd_en & ~empty_q;
    rd_bin_d  = rd_bin_q + {{(PTR_W-1){1'b0}}, rd_inc};
    gray_wide = bin2gray(32'(rd_bin_d));
    rd_gray_d = gray_wide[PTR_W-1:0];
    wbin_wide = gray2bin(32'(sync_wptr));
    w_bin     = wbin_wide[PTR_W-1:0];
    // Modulo-2**PTR_W difference copes with the write pointer having wrapped.
    level_d   = w_bin - rd_bin_d;
  end

  always_ff @(posedge Dst_clk) begin
    if (!rst) begin
      rd_bin_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      empty_q     <= 1'b1;
      aempty_q    <= 1'b1;
      underflow_q <= 1'b0;
    end else begin
      rd_bin_q    <= rd_bin_d;
      rd_ptr_q    <= rd_gray_d;
      level_q     <= level_d;
      empty_q     <= (rd_gray_d == sync_wptr);
      aempty_q    <= (level_d <= AE_TH);
      underflow_q <= rd_en & empty_q;
    end
  end

  assign rd_addr      = rd_bin_q[ADDR_WIDTH-1:0];
  assign rd_ptr       = rd_ptr_q;
  assign rd_level     = level_q;
  assign empty        = empty_q;
  assign almost_empty = aempty_q;
  assign rd_underflow = underflow_q;

endmodule
